// File: rtl/lane_mem_sequencer_pkg.sv
// Shared constants and state encoding for the lane memory sequencer.
package lane_mem_sequencer_pkg;
   localparam int LANE_W_DEF = 64;
   localparam int N_DEF      = 5;
   // Smallest address width that still covers every lane of the default grid.
   localparam int ADDR_W_DEF = $clog2(N_DEF * N_DEF);
   localparam int CNT_W      = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_ISSUE,
      S_COMPUTE,
      S_WRITE,
      S_NEXT,
      S_DONE
   } state_e;
endpackage

// File: rtl/lane_mem_sequencer_xy_counter.sv
// Row-major 2-D wrap counter: x is the inner index, y the outer one.
module lane_xy_counter
   import lane_mem_sequencer_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic             last_o
);
   localparam logic [CNT_W-1:0] MAX = CNT_W'(N - 1);

   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (inc_i) begin
         if (x_q == MAX) begin
            x_d = '0;
            y_d = (y_q == MAX) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == MAX) && (y_q == MAX);
endmodule

// File: rtl/lane_mem_sequencer.sv
// Walks an N x N grid of lanes: read, hand to the datapath, write the result back.
module lane_mem_sequencer
   import lane_mem_sequencer_pkg::*;
#(
   parameter int LANE_W = LANE_W_DEF,
   parameter int N      = N_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [LANE_W-1:0] mem_rdata,
   output logic [LANE_W-1:0] mem_wdata,
   output logic              dp_valid,
   input  logic              dp_ready,
   output logic [LANE_W-1:0] dp_lane,
   output logic [2:0]        lane_x,
   output logic [2:0]        lane_y,
   input  logic              dp_res_valid,
   input  logic [LANE_W-1:0] dp_res
);
   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [LANE_W-1:0]   res_q, res_d;
   logic                cnt_inc, cnt_clr, cnt_last;
   logic [CNT_W-1:0]    cnt_x, cnt_y;
   logic [ADDR_W-1:0]   lin_addr;

   lane_xy_counter #(.N(N)) u_xy (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (cnt_inc),
      .clr_i  (cnt_clr),
      .x_o    (cnt_x),
      .y_o    (cnt_y),
      .last_o (cnt_last)
   );

   assign lin_addr = ADDR_W'(cnt_y) * ADDR_W'(N) + ADDR_W'(cnt_x);
   assign lane_x   = cnt_x;
   assign lane_y   = cnt_y;

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      res_d     = res_q;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      dp_valid  = 1'b0;
      dp_lane   = '0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               cnt_clr = 1'b1;
               state_d = S_READ;
            end
         end
         S_READ: begin
            mem_rd   = 1'b1;
            mem_addr = lin_addr;
            state_d  = S_LATCH;
         end
         S_LATCH: begin
            lane_d  = mem_rdata;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            dp_valid = 1'b1;
            dp_lane  = lane_q;
            if (dp_ready) state_d = S_COMPUTE;
         end
         // Result strobes seen in any other state are deliberately dropped.
         S_COMPUTE: begin
            if (dp_res_valid) begin
               res_d   = dp_res;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_wr    = 1'b1;
            mem_addr  = lin_addr;
            mem_wdata = res_q;
            state_d   = S_NEXT;
         end
         S_NEXT: begin
            if (cnt_last) begin
               state_d = S_DONE;
            end else begin
               cnt_inc = 1'b1;
               state_d = S_READ;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         res_q   <= res_d;
      end
   end
endmodule

// File: doc/lane_mem_sequencer.md
LANE_MEM_SEQUENCER -- requirements
Module: lane_mem_sequencer

Interface
REQ-001 Parameter LANE_W, 64, lane data width in bits.
REQ-002 Parameter N, 5, grid dimension; the block walks N*N lanes.
REQ-003 Parameter ADDR_W, 5, memory address width; must satisfy 2^ADDR_W >= N*N.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin a full-grid pass; sampled only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at the end of a pass.
REQ-010 mem_rd  out  1  memory read strobe.
REQ-011 mem_wr  out  1  memory write strobe.
REQ-012 mem_addr  out  ADDR_W  lane address, equal to y*N+x.
REQ-013 mem_rdata  in  LANE_W  read data, valid the cycle after mem_rd.
REQ-014 mem_wdata  out  LANE_W  write data.
REQ-015 dp_valid  out  1  lane offered to the datapath.
REQ-016 dp_ready  in  1  datapath accepts the lane.
REQ-017 dp_lane  out  LANE_W  lane operand.
REQ-018 lane_x, lane_y  out  3 each  current lane coordinates, used for the datapath offset.
REQ-019 dp_res_valid  in  1  datapath result valid.
REQ-020 dp_res  in  LANE_W  datapath result.

Function
REQ-021 States: IDLE, READ, LATCH, ISSUE, COMPUTE, WRITE, NEXT, DONE.
REQ-022 IDLE: start=1 clears x and y to 0 and moves to READ; start=0 stays in IDLE.
REQ-023 READ: mem_rd=1 with mem_addr=y*N+x for exactly one cycle, then LATCH.
REQ-024 LATCH: mem_rdata is captured into the lane register, then ISSUE.
REQ-025 ISSUE: dp_valid=1 and dp_lane=lane register; dp_valid is held until dp_ready=1, and the same-cycle handshake moves to COMPUTE.
REQ-026 COMPUTE: wait for dp_res_valid; when it is seen, capture dp_res and move to WRITE. dp_res_valid outside COMPUTE is ignored.
REQ-027 WRITE: mem_wr=1, mem_addr=y*N+x, mem_wdata=captured result for one cycle, then NEXT.
REQ-028 NEXT: if x=N-1 and y=N-1, go to DONE. Otherwise go to READ, where x=N-1 wraps x to 0 and increments y, else x increments.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 The traversal is row-major: x is inner, y is outer, covering addresses 0..N*N-1 in order.
REQ-031 mem_rd and mem_wr are never high in the same cycle.
REQ-032 mem_addr is 0 in states that do not access memory.
REQ-033 start while busy is ignored and is not queued.
REQ-034 Stall tolerance: dp_ready and dp_res_valid may be low for any number of cycles; no timeout.
REQ-035 With dp_ready=1 and dp_res_valid arriving in the first COMPUTE cycle, each lane takes 6 cycles and done occurs 6*N*N+1 cycles after start is sampled.
REQ-036 Address arithmetic is y*N+x truncated to ADDR_W, computed from counters that are 3 bits wide.

Reset
REQ-037 rst=1 forces IDLE and sets x=y=0, lane and result registers to 0, and every output to 0.
REQ-038 rst mid-pass aborts immediately: no further mem_wr, no done pulse, and the next pass restarts at lane (0,0).

Structure
REQ-039 A shared package holds the state encoding, the default LANE_W/N/ADDR_W constants, and the address-width helper constant.
REQ-040 One sub-module, lane_xy_counter: a 2-D wrap counter with inc, clr, x, y and last outputs. The FSM and the datapath registers stay in the top module.

Verification
REQ-041 rst, then start with dp_ready=1 and single-cycle result latency, and memory preloaded with addr i = i: writes occur to addresses 0..24 in order with data f(i); done occurs at cycle 151 after start; busy falls the cycle after done.
REQ-042 Hold dp_ready=0 for 10 cycles at lane (2,3): dp_valid and dp_lane stay stable, there is no mem_wr, and the pass completes 10 cycles late.
REQ-043 Pulse dp_res_valid during ISSUE, then again in COMPUTE: only the COMPUTE result is written.
REQ-044 Assert rst during WRITE of lane 12: mem_wr is 0 the next cycle, the block is in IDLE, and no done pulse occurs. A new start reads address 0 first.
REQ-045 Assert start repeatedly while busy: exactly one done pulse and 25 writes occur.
REQ-046 Check every cycle: mem_rd and mem_wr are mutually exclusive, and lane_x/lane_y equal mem_addr decomposed during READ and WRITE.
